// File: rtl/decode_bus_pkg.sv
// Shared types and constants for the fetch-to-decode bus.
package decode_bus_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pred_taken;
        logic        valid;
    } FetchToDecodeBusPacket;

    localparam int unsigned FETCH_DECODE_FIFO_DEPTH = 4;
    localparam logic [15:0] DROP_CNT_SAT            = 16'hFFFF;

endpackage

// File: rtl/fetch_to_decode_receiver_if.sv
// Bus-side and decode-side handshake signals of the fetch-to-decode receiver.
interface fetch_to_decode_receiver_if;
    import decode_bus_pkg::*;

    logic                  bus_is_busy;
    FetchToDecodeBusPacket bus_data;
    logic                  bus_recv_ack;
    logic                  out_valid;
    FetchToDecodeBusPacket out_packet;
    logic                  out_ready;

    modport master (
        output bus_is_busy,
        output bus_data,
        input  bus_recv_ack,
        input  out_valid,
        input  out_packet,
        output out_ready
    );

    modport slave (
        input  bus_is_busy,
        input  bus_data,
        output bus_recv_ack,
        output out_valid,
        output out_packet,
        input  out_ready
    );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with clear; head is the oldest entry, count is the occupancy.
module sync_fifo #(
    parameter int unsigned Depth = 4,
    parameter type T = logic,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            clear_i,
    input  logic            push_i,
    input  T                data_i,
    input  logic            pop_i,
    output T                head_o,
    output logic [CntW-1:0] count_o
);

    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [CntW-1:0] count_q, count_d;
    T                mem_q [Depth];

    logic full, empty, do_push, do_pop;

    assign full    = (count_q == CntW'(Depth));
    assign empty   = (count_q == '0);
    assign do_push = push_i & ~full;
    assign do_pop  = pop_i & ~empty;

    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        if (clear_i) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + PtrW'(1);
            if (do_pop)  rptr_d = rptr_q + PtrW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; entries are only observed while count is nonzero.
    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i) mem_q[wptr_q] <= data_i;
    end

    assign head_o  = mem_q[rptr_q];
    assign count_o = count_q;

    a_no_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
        !(push_i && full && !clear_i));
    a_no_underflow: assert property (@(posedge clk_i) disable iff (reset_i)
        !(pop_i && empty && !clear_i));
    a_count_bound: assert property (@(posedge clk_i) disable iff (reset_i)
        count_q <= CntW'(Depth));

endmodule

// File: rtl/fetch_to_decode_receiver.sv
// Consumer end of the fetch-to-decode bus: acks packets into a FIFO, feeds decode,
// handles flush and keeps receive/drop statistics.
module fetch_to_decode_receiver
    import decode_bus_pkg::*;
#(
    parameter int unsigned DEPTH = FETCH_DECODE_FIFO_DEPTH,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       flush_i,
    fetch_to_decode_receiver_if.slave  bus_if,
    output logic [CNT_W-1:0]           occupancy_o,
    output logic [31:0]                received_count_o,
    output logic [15:0]                dropped_count_o
);

    logic             pull, push, pop;
    logic [CNT_W-1:0] occupancy;
    logic [31:0]      received_q, received_d;
    logic [15:0]      dropped_q, dropped_d;
    logic [16:0]      drop_sum;

    // Flush may ack even when full because the acked packet is discarded anyway.
    assign pull = bus_if.bus_is_busy & ~reset_i & (flush_i | (occupancy < CNT_W'(DEPTH)));
    assign push = pull & ~flush_i;
    assign pop  = bus_if.out_valid & bus_if.out_ready & ~flush_i;

    assign bus_if.bus_recv_ack = pull;
    assign bus_if.out_valid    = (occupancy != '0);

    sync_fifo #(
        .Depth (DEPTH),
        .T     (FetchToDecodeBusPacket)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (flush_i),
        .push_i  (push),
        .data_i  (bus_if.bus_data),
        .pop_i   (pop),
        .head_o  (bus_if.out_packet),
        .count_o (occupancy)
    );

    always_comb begin
        received_d = received_q;
        dropped_d  = dropped_q;
        drop_sum   = 17'(dropped_q) + 17'(occupancy) + 17'(pull);
        if (push) received_d = received_q + 32'd1;
        if (flush_i) begin
            dropped_d = (drop_sum > 17'(DROP_CNT_SAT)) ? DROP_CNT_SAT : drop_sum[15:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            received_q <= '0;
            dropped_q  <= '0;
        end else begin
            received_q <= received_d;
            dropped_q  <= dropped_d;
        end
    end

    assign occupancy_o      = occupancy;
    assign received_count_o = received_q;
    assign dropped_count_o  = dropped_q;

endmodule

// File: tb/tb_fetch_to_decode_receiver.sv
// Scoreboard bench for fetch_to_decode_receiver: acked packets are queued as expected
// output and a negedge monitor compares every accepted head against the queue.
module tb_fetch_to_decode_receiver;
    import decode_bus_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic [CNT_W-1:0] occupancy;
    logic [31:0]      received_count;
    logic [15:0]      dropped_count;

    int n_cmp = 0;
    int n_err = 0;

    FetchToDecodeBusPacket exp_q[$];

    fetch_to_decode_receiver_if bus_if ();

    fetch_to_decode_receiver #(
        .DEPTH (DEPTH)
    ) dut (
        .clk_i            (clk),
        .reset_i          (rst),
        .flush_i          (flush),
        .bus_if           (bus_if.slave),
        .occupancy_o      (occupancy),
        .received_count_o (received_count),
        .dropped_count_o  (dropped_count)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic FetchToDecodeBusPacket mk_pkt(logic [31:0] pc);
        FetchToDecodeBusPacket p;
        p.pc         = pc;
        p.instr      = pc ^ 32'hDEAD_BEEF;
        p.pred_taken = pc[2];
        p.valid      = 1'b1;
        return p;
    endfunction

    // Monitor: every head accepted by decode must match the oldest expected packet.
    always @(negedge clk) begin
        if (!rst && !flush && bus_if.out_valid && bus_if.out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL out_unexpected: got pc 0x%0h, expected no output",
                         bus_if.out_packet.pc);
            end else begin
                FetchToDecodeBusPacket e;
                e = exp_q.pop_front();
                check("out_packet", 64'(bus_if.out_packet), 64'(e));
            end
        end
    end

    // One cycle of stimulus; ack is checked at negedge and acked packets become expected.
    task automatic step(input logic busy, input logic [31:0] pc, input logic ready,
                        input logic fl, input logic exp_ack);
        bus_if.bus_is_busy = busy;
        bus_if.bus_data    = mk_pkt(pc);
        bus_if.out_ready   = ready;
        flush              = fl;
        @(negedge clk);
        check("bus_recv_ack", 64'(bus_if.bus_recv_ack), 64'(exp_ack));
        if (bus_if.bus_recv_ack && !fl && !rst) exp_q.push_back(mk_pkt(pc));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst                = 1'b1;
        flush              = 1'b0;
        bus_if.bus_is_busy = 1'b0;
        bus_if.bus_data    = mk_pkt(32'h0);
        bus_if.out_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_occupancy", 64'(occupancy), 64'd0);
        check("reset_out_valid", 64'(bus_if.out_valid), 64'd0);
        check("reset_received", 64'(received_count), 64'd0);
        check("reset_dropped", 64'(dropped_count), 64'd0);
        rst = 1'b0;

        // Single packet
        step(1'b1, 32'h100, 1'b0, 1'b0, 1'b1);
        check("single_out_valid", 64'(bus_if.out_valid), 64'd1);
        check("single_pc", 64'(bus_if.out_packet.pc), 64'h100);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        check("single_occupancy", 64'(occupancy), 64'd0);
        check("single_received", 64'(received_count), 64'd1);

        // Fill: four acked, fifth held until one pop frees an entry
        for (int i = 0; i < 4; i++) step(1'b1, 32'h200 + i, 1'b0, 1'b0, 1'b1);
        check("fill_occupancy", 64'(occupancy), 64'd4);
        step(1'b1, 32'h204, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h204, 1'b1, 1'b0, 1'b0);
        check("fill_after_pop", 64'(occupancy), 64'd3);
        step(1'b1, 32'h204, 1'b0, 1'b0, 1'b1);
        check("fill_refull", 64'(occupancy), 64'd4);
        repeat (5) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        check("fill_drained", 64'(occupancy), 64'd0);
        check("fill_received", 64'(received_count), 64'd6);

        // Streaming
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 32'h1000 + i, 1'b1, 1'b0, 1'b1);
            check("stream_occ_le1", 64'(occupancy <= 1), 64'd1);
            check("stream_no_bubble", 64'(bus_if.out_valid), 64'd1);
        end
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        check("stream_received", 64'(received_count), 64'd106);
        check("stream_occupancy", 64'(occupancy), 64'd0);

        // Flush with three buffered and a busy bus
        for (int i = 0; i < 3; i++) step(1'b1, 32'h300 + i, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h303, 1'b1, 1'b1, 1'b1);
        exp_q.delete();
        check("flush_occupancy", 64'(occupancy), 64'd0);
        check("flush_dropped", 64'(dropped_count), 64'd4);
        check("flush_received", 64'(received_count), 64'd109);
        check("flush_out_valid", 64'(bus_if.out_valid), 64'd0);

        // Reset mid-stream with a pending bus packet
        for (int i = 0; i < 2; i++) step(1'b1, 32'h400 + i, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        step(1'b1, 32'h500, 1'b0, 1'b0, 1'b0);
        exp_q.delete();
        check("rst_occupancy", 64'(occupancy), 64'd0);
        check("rst_out_valid", 64'(bus_if.out_valid), 64'd0);
        check("rst_received", 64'(received_count), 64'd0);
        check("rst_dropped", 64'(dropped_count), 64'd0);
        rst = 1'b0;
        step(1'b1, 32'h500, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        check("rst_after_received", 64'(received_count), 64'd1);
        check("rst_after_occupancy", 64'(occupancy), 64'd0);

        // Drop counter saturation under held flush
        step(1'b1, 32'h600, 1'b0, 1'b1, 1'b1);
        check("sat_first_drop", 64'(dropped_count), 64'd1);
        bus_if.bus_is_busy = 1'b1;
        flush              = 1'b1;
        repeat (69999) @(posedge clk);
        #1;
        check("sat_dropped", 64'(dropped_count), 64'hFFFF);
        check("sat_received", 64'(received_count), 64'd1);
        step(1'b1, 32'h601, 1'b0, 1'b1, 1'b1);
        check("sat_hold", 64'(dropped_count), 64'hFFFF);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
